// File: rtl/npc_lsu_pkg.sv
// npc_lsu_pkg: shared types and constants for the npc load/store unit.
//   state_e      - LSU control states (IDLE, REQ, WAIT, RESP)
//   ERR_*        - 2-bit response error codes
//   F3_*         - RISC-V load/store funct3 encodings
//   size_mask()  - byte-enable pattern for an access size (funct3[1:0])
package npc_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // funct3[1:0] encodes log2(access bytes) for every legal load/store.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// npc_lsu_align: purely combinational lane logic for the LSU.
//   wen_i        - 1 = store, 0 = load (selects the legal funct3 set)
//   funct3_i     - RISC-V funct3 of the access
//   off_i        - byte offset of the address within the data word
//   wdata_i      - LSB-justified store data
//   rdata_i      - raw memory word
//   wdata_sh_o   - store data shifted into its byte lanes
//   wmask_o      - byte enables (all zero for loads)
//   rdata_ext_o  - load data shifted down, truncated and sign/zero-extended
//   legal_o      - funct3 is a valid encoding for this XLEN and direction
//   misaligned_o - address is not naturally aligned for the access size
module npc_lsu_align
    import npc_lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic             wen_i,
    input  logic [2:0]       funct3_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [XLEN-1:0]  wdata_sh_o,
    output logic [NB-1:0]    wmask_o,
    output logic [XLEN-1:0]  rdata_ext_o,
    output logic             legal_o,
    output logic             misaligned_o
);

    logic [OFF_W+2:0] sh_amt;
    logic [7:0]       smask;
    logic [XLEN-1:0]  rdata_sh;

    // Byte offset times eight, as a bit shift amount.
    assign sh_amt     = {off_i, 3'b000};
    assign smask      = size_mask(funct3_i[1:0]);
    assign wdata_sh_o = wdata_i << sh_amt;
    assign wmask_o    = wen_i ? (smask[NB-1:0] << off_i) : '0;
    assign rdata_sh   = rdata_i >> sh_amt;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        legal_o = 1'b0;
        if (wen_i) begin
            case (funct3_i)
                F3_B, F3_H, F3_W: legal_o = 1'b1;
                F3_D:             legal_o = 1'(XLEN == 64);
                default:          legal_o = 1'b0;
            endcase
        end else begin
            case (funct3_i)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: legal_o = 1'b1;
                F3_D, F3_WU:                    legal_o = 1'(XLEN == 64);
                default:                        legal_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'd1:    misaligned_o = off_i[0];
            2'd2:    misaligned_o = |off_i[1:0];
            2'd3:    misaligned_o = |off_i;
            default: misaligned_o = 1'b0;
        endcase
    end

    // A size cast of a signed operand sign-extends; of an unsigned one it
    // zero-extends.
    always_comb begin
        rdata_ext_o = '0;
        case (funct3_i)
            F3_B:    rdata_ext_o = XLEN'($signed(rdata_sh[7:0]));
            F3_H:    rdata_ext_o = XLEN'($signed(rdata_sh[15:0]));
            F3_W:    rdata_ext_o = XLEN'($signed(rdata_sh[31:0]));
            F3_D:    rdata_ext_o = rdata_sh;
            F3_BU:   rdata_ext_o = XLEN'(rdata_sh[7:0]);
            F3_HU:   rdata_ext_o = XLEN'(rdata_sh[15:0]);
            F3_WU:   rdata_ext_o = XLEN'(rdata_sh[31:0]);
            default: rdata_ext_o = '0;
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// npc_lsu: multi-cycle load/store unit for the npc RV core.
//   clk, rst                - clock, synchronous active-low reset
//   req_valid/req_ready     - core request handshake (ready only in IDLE)
//   req_wen/funct3/addr/wdata - request payload, latched on acceptance
//   resp_valid/resp_ready   - response handshake toward the core
//   resp_rdata/resp_err     - extended load data / error code
//   mem_valid/mem_ready     - word-aligned memory request handshake
//   mem_wen/addr/wdata/wmask - memory request payload
//   mem_rvalid/mem_rdata    - read data or write acknowledge
module npc_lsu
    import npc_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam bit TO_EN = (TIMEOUT != 0);
    // The counter holds the number of REQ/WAIT cycles already completed, so
    // the cycle in which it reads TIMEOUT-1 is the TIMEOUT-th one. Using >=
    // keeps the timeout armed in WAIT after a handshake won at the limit.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic              wen_q;
    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [NB-1:0]     wmask_q;
    logic [XLEN-1:0]   rdata_q;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              in_idle;
    logic              al_wen;
    logic [2:0]        al_funct3;
    logic [OFF_W-1:0]  al_off;
    logic [XLEN-1:0]   al_wdata_sh;
    logic [NB-1:0]     al_wmask;
    logic [XLEN-1:0]   al_rdata_ext;
    logic              al_legal;
    logic              al_mis;
    logic              timeout_hit;

    // One aligner serves both ends: in IDLE it checks and lane-shifts the
    // incoming request; afterwards it sees the latched funct3/offset so the
    // read data can be extended when it arrives.
    assign in_idle   = (state_q == IDLE);
    assign al_wen    = in_idle ? req_wen    : wen_q;
    assign al_funct3 = in_idle ? req_funct3 : funct3_q;
    assign al_off    = in_idle ? req_addr[OFF_W-1:0] : off_q;

    npc_lsu_align #(.XLEN(XLEN)) u_align (
        .wen_i        (al_wen),
        .funct3_i     (al_funct3),
        .off_i        (al_off),
        .wdata_i      (req_wdata),
        .rdata_i      (mem_rdata),
        .wdata_sh_o   (al_wdata_sh),
        .wmask_o      (al_wmask),
        .rdata_ext_o  (al_rdata_ext),
        .legal_o      (al_legal),
        .misaligned_o (al_mis)
    );

    assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);

    // NOTE: clocked state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completing handshake is tested before the timeout so it wins a tie.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = (al_legal && !al_mis) ? REQ : RESP;
            REQ: begin
                if (mem_ready)        state_d = WAIT;
                else if (timeout_hit) state_d = RESP;
            end
            WAIT: if (mem_rvalid || timeout_hit) state_d = RESP;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wen_q    <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wen_q    <= req_wen;
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[OFF_W-1:0];
                        addr_q   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        wdata_q  <= al_wdata_sh;
                        wmask_q  <= al_wmask;
                        rdata_q  <= '0;
                        cnt_q    <= '0;
                        if (!al_legal)   err_q <= ERR_ILLEGAL;
                        else if (al_mis) err_q <= ERR_MISALIGN;
                        else             err_q <= ERR_OK;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!mem_ready && timeout_hit) err_q <= ERR_TIMEOUT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_rvalid) begin
                        rdata_q <= wen_q ? '0 : al_rdata_ext;
                        err_q   <= ERR_OK;
                    end else if (timeout_hit) begin
                        err_q <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by state so nothing stale leaks outside REQ/RESP.
    always_comb begin
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = ERR_OK;
        case (state_q)
            IDLE: req_ready = 1'b1;
            REQ: begin
                mem_valid = 1'b1;
                mem_wen   = wen_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wmask = wmask_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: randomized self-checking bench for npc_lsu (XLEN=32, TIMEOUT=4).
// A transaction-level model predicts the memory request, the response and
// its latency; a compare process checks the DUT against it every cycle.
module tb_npc_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_valid, mem_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    npc_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mwmask;
        logic        wen;
        logic        goes_mem;
    } exp_t;

    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    bit   in_txn = 1'b0;
    exp_t exp_cur;
    logic [31:0] last_maddr, last_mwdata;
    logic [3:0]  last_mwmask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what a RISC-V load/store on a 32-bit word memory
    // must produce, ignoring timing.
    function automatic exp_t model(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rword);
        exp_t e;
        bit legal;
        int nbytes, off, m;
        logic [31:0] v;
        e = '0;
        e.wen = wen;
        if (wen) legal = (f3 inside {3'd0, 3'd1, 3'd2});
        else     legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes = 1 << f3[1:0];
        off    = int'(addr % 4);
        if (!legal) begin
            e.err = 2'b11;
        end else if (addr % nbytes != 0) begin
            e.err = 2'b01;
        end else begin
            e.goes_mem = 1'b1;
            e.maddr    = addr - off;
            if (wen) begin
                e.mwdata = wdata << (8 * off);
                m        = ((1 << nbytes) - 1) << off;
                e.mwmask = 4'(m);
            end else begin
                v = rword >> (8 * off);
                if (nbytes == 1) v = v % 256;
                if (nbytes == 2) v = v % 65536;
                // Signed narrow loads: values with the top bit set wrap negative.
                if (!f3[2] && nbytes < 4 && v >= (32'd1 << (8 * nbytes - 1)))
                    v = v - (32'd1 << (8 * nbytes));
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // Per-cycle compare, sampled 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            if (!in_txn) begin
                check("idle_req_ready", req_ready, 1);
                check("idle_mem_valid", mem_valid, 0);
                check("idle_resp_valid", resp_valid, 0);
            end else begin
                if (mem_valid === 1'b1) begin
                    check("mem_allowed", exp_cur.goes_mem, 1);
                    check("mem_addr", mem_addr, exp_cur.maddr);
                    check("mem_wen", mem_wen, exp_cur.wen);
                    check("mem_wmask", mem_wmask, exp_cur.mwmask);
                    if (exp_cur.wen) check("mem_wdata", mem_wdata, exp_cur.mwdata);
                end
                if (resp_valid === 1'b1) begin
                    check("resp_rdata", resp_rdata, exp_cur.rdata);
                    check("resp_err", resp_err, exp_cur.err);
                end
            end
        end
    end

    // One transaction: k = REQ cycle on which mem_ready is given, j = WAIT
    // cycle on which mem_rvalid is given, stall = cycles resp_ready stays low.
    task automatic run_txn(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword,
                           input int k, input int j, input int stall,
                           output logic [31:0] o_rdata, output logic [1:0] o_err,
                           output int o_lat, output int o_nreq);
        exp_t e;
        int exp_lat, n_wait, cyc;
        bit in_wait;
        e = model(wen, f3, addr, wdata, rword);
        if (!e.goes_mem) begin
            exp_lat = 1;
        end else if (k > TO) begin
            exp_lat = TO + 1;
            e.err = 2'b10; e.rdata = '0;
        end else if (j == 1 || k + j - 1 < TO) begin
            exp_lat = k + j + 1;
        end else begin
            exp_lat = ((k + 1 > TO) ? k + 1 : TO) + 1;
            e.err = 2'b10; e.rdata = '0;
        end
        @(negedge clk);
        exp_cur = e;
        check("accept_ready", req_ready, 1);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        in_txn = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_wen = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        cyc = 1; o_nreq = 0; n_wait = 0; in_wait = 1'b0;
        while (resp_valid !== 1'b1 && cyc < 40) begin
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (mem_valid === 1'b1) begin
                o_nreq++;
                last_maddr = mem_addr; last_mwdata = mem_wdata; last_mwmask = mem_wmask;
                if (o_nreq == k) mem_ready = 1'b1;
            end else if (in_wait) begin
                n_wait++;
                if (n_wait == j) begin mem_rvalid = 1'b1; mem_rdata = rword; end
            end
            if (mem_ready) in_wait = 1'b1;
            @(negedge clk);
            cyc++;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        o_lat = cyc; o_rdata = resp_rdata; o_err = resp_err;
        check("resp_seen", resp_valid, 1);
        check("latency", cyc, exp_lat);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", resp_valid, 1);
            check("stall_rdata", resp_rdata, o_rdata);
            check("stall_err", resp_err, o_err);
            check("stall_req_ready", req_ready, 0);
        end
        // Handshake cycle also offers a new request that must not be taken.
        resp_ready = 1'b1;
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'd0; req_addr = $urandom;
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b0;
        check("post_resp_idle", {req_ready, mem_valid, resp_valid}, 3'b100);
        in_txn = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  er;
        int lat, nreq;
        bit wen;
        logic [2:0]  f3;
        logic [31:0] addr;

        rst = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0; resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {req_ready, mem_valid, resp_valid, mem_wen}, 4'b1000);
        check("rst_resp", {resp_rdata, 30'd0, resp_err}, 64'd0);
        rst = 1'b1;
        chk_en = 1'b1;

        // lb / lbu with a negative byte in lane 3.
        run_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1, 1, 0, rd, er, lat, nreq);
        check("lb_rdata", rd, 32'hFFFF_FF80);
        check("lb_err", er, 2'b00);
        check("lb_maddr", last_maddr, 32'h8000_0000);
        check("lb_wmask", last_mwmask, 4'b0000);
        run_txn(1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1, 1, 0, rd, er, lat, nreq);
        check("lbu_rdata", rd, 32'h0000_0080);

        // sh into the upper half, zero-wait memory.
        run_txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 1, 1, 0, rd, er, lat, nreq);
        check("sh_wdata", last_mwdata, 32'hABCD_0000);
        check("sh_wmask", last_mwmask, 4'b1100);
        check("sh_latency", lat, 3);
        check("sh_rdata", rd, 32'h0);

        // Error paths: misaligned lw, illegal funct3 for RV32.
        run_txn(1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 1, 1, 0, rd, er, lat, nreq);
        check("mis_err", er, 2'b01);
        check("mis_lat", lat, 1);
        check("mis_nomem", nreq, 0);
        run_txn(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1, 1, 0, rd, er, lat, nreq);
        check("ill_err", er, 2'b11);
        check("ill_lat", lat, 1);

        // Timeout with mem_ready never given, then a stray mem_rvalid in IDLE.
        run_txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 100, 1, 0, rd, er, lat, nreq);
        check("to_err", er, 2'b10);
        check("to_nreq", nreq, TO);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid", {resp_valid, req_ready}, 2'b01);

        // Response held for 5 cycles.
        run_txn(1'b0, 3'b101, 32'h8000_0022, 32'h0, 32'h8765_4321, 2, 2, 5, rd, er, lat, nreq);
        check("stall_rd_val", rd, 32'h0000_8765);

        // Reset while in WAIT.
        @(negedge clk);
        chk_en = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstw_req", mem_valid, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rstw_wait", {mem_valid, resp_valid, req_ready}, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstw_ctrl", {req_ready, mem_valid, resp_valid, mem_wen}, 4'b1000);
        check("rstw_mem", {mem_addr, mem_wdata}, 64'd0);
        check("rstw_resp", {resp_rdata, mem_wmask, resp_err}, 38'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rstw_ignore", {resp_valid, mem_valid, req_ready}, 3'b001);
        @(negedge clk);
        check("rstw_ignore2", resp_valid, 0);
        chk_en = 1'b1;

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            wen  = 1'($urandom);
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & ~32'h3;
            run_txn(wen, f3, addr, $urandom, $urandom,
                    $urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(0, 3),
                    rd, er, lat, nreq);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/npc_lsu.md
Name: npc_lsu

Overview:
- Multi-cycle load/store unit for the npc RV core.
- Replaces direct combinational `v_pmem_read`/`v_pmem_write` calls with a registered valid/ready request port toward the core and a handshaked word-aligned memory port toward the DPI memory wrapper or a bus bridge.
- Parametrised in data width (RV32/RV64).
- Does byte-lane alignment, write-mask generation, sign/zero extension, misalignment/illegal detection and a bus timeout.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before error; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- req_valid  in  1  core issues a memory op.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- resp_valid  out  1  result/completion available.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts the request.
- mem_wen  out  1  write request.
- mem_addr  out  ADDR_W  req_addr with the low log2(XLEN/8) bits cleared.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wmask  out  XLEN/8  byte enables; 0 for reads.
- mem_rvalid  in  1  read data / write acknowledge.
- mem_rdata  in  XLEN  raw word.

Behaviour:
- Reset (rst=0 at posedge):
  - State goes to IDLE; timeout counter cleared.
  - All outputs 0 except req_ready=1.
  - Reset overrides any in-flight transaction; a late mem_rvalid is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a posedge, latch wen/funct3/addr/wdata.
  - If funct3 is illegal → RESP with err 11.
  - Else if misaligned → RESP with err 01.
  - Else → REQ.
  - mem_rvalid in IDLE is ignored.
- Legal funct3:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000, 001, 010.
  - XLEN=64 additionally allows 011 (ld/sd) and 110 (lwu).
  - Every other encoding is illegal.
- Alignment requirement: halfword addr[0]=0; word addr[1:0]=0; double addr[2:0]=0.
- REQ:
  - mem_valid=1; outputs stable until mem_ready.
  - mem_valid & mem_ready → WAIT.
- WAIT:
  - mem_valid=0.
  - On mem_rvalid: capture the aligned/extended result → RESP with err 00.
- Timeout:
  - The counter increments each cycle in REQ or WAIT.
  - When it equals TIMEOUT (TIMEOUT≠0) with no completing handshake → RESP with err 10; mem_valid drops.
  - If the completing handshake and the timeout coincide, the handshake wins.
- RESP:
  - resp_valid=1 with data/err held stable.
  - resp_valid & resp_ready → IDLE.
  - No new request is accepted in the same cycle.
- Lane offset: off = addr[log2(XLEN/8)-1:0].
  - mem_wdata = req_wdata << (8*off).
  - mem_wmask = size-mask << off, where size-mask is 1/3/F/FF bytes.
  - Load: shift mem_rdata right by 8*off, truncate to size, then sign-extend (lb/lh/lw under RV64) or zero-extend (lbu/lhu/lwu).
  - XLEN=32 lw passes the word through unchanged.
- Latency:
  - Error path: resp_valid in the cycle after acceptance.
  - Zero-wait memory (mem_ready and next-cycle mem_rvalid): resp_valid 3 cycles after acceptance.

Decomposition:
- Package npc_lsu_pkg:
  - state enum (IDLE, REQ, WAIT, RESP);
  - err code constants (ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL);
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
- One combinational sub-module, npc_lsu_align (parameter XLEN):
  - inputs: funct3, off, wdata, rdata;
  - outputs: wdata_sh, wmask, rdata_ext, legal, misaligned.
- The FSM, counter and registers stay in npc_lsu.

Test Plan:
- lb, addr 0x80000003, mem_rdata 0x80FF1234:
  - mem_addr = 0x80000000, mem_wmask = 0;
  - resp_rdata = 0xFFFFFF80, err 00.
  - Same with lbu → 0x00000080.
- sh, addr 0x80000002, wdata 0x0000ABCD, mem_ready=1 immediately:
  - mem_wdata = 0xABCD0000, mem_wmask = 4'b1100;
  - resp_valid 3 cycles after acceptance, rdata 0.
- lw at 0x80000001, and funct3=011 with XLEN=32:
  - err 01 and err 11 respectively, resp_valid the cycle after acceptance;
  - mem_valid never asserted.
- TIMEOUT=4, mem_ready held 0:
  - mem_valid high 4 cycles, then resp_err 10.
  - A later mem_rvalid in IDLE causes no response.
- resp_ready held 0 for 5 cycles:
  - resp_valid/rdata/err stable; req_ready stays 0;
  - accepts a new request only after the resp handshake.
- rst=0 during WAIT:
  - next cycle all outputs 0, req_ready=1;
  - mem_rvalid in the following cycle is ignored.
